mvm_job_sequencer: RTL and testbench
====================================

Name: mvm_job_sequencer

Overview:
- Sequences one matrix-vector multiply job through the streaming mat-vect engine. The engine expects the vector and row 0 in lockstep, then the remaining rows, and returns one accumulated result per row.
- The block takes a job command holding the matrix and vector base addresses. It fetches operands from a single-port synchronous RAM, drives the engine's vector and row-stream ports, and collects the N row results into a result write port.
- It sits between the job-control logic and one engine instance.

Parameters:
N, 2, matrix dimension (rows = cols = vector length), N >= 2
DW, 8, operand width
AW, 8, operand RAM address width
RW, 2*DW+$clog2(N), result width

Ports:
aclk  in  1  clock
areset  in  1  reset, asynchronous, active-high
cmd_valid  in  1  job request
cmd_ready  out  1  sequencer idle, accepts job
cmd_mat_base  in  AW  matrix base address; row-major, element (r,c) at base+r*N+c
cmd_vec_base  in  AW  vector base address; element k at base+k
mem_rd_en  out  1  RAM read strobe
mem_rd_addr  out  AW  RAM read address
mem_rd_data  in  DW  RAM data, valid exactly 1 cycle after mem_rd_en
vec_data  out  DW  vector element to engine
vec_valid  out  1  vector element valid
vec_rdy  in  1  engine accepts vector element
m_axis_tdata  out  DW  matrix element to engine
m_axis_tvalid  out  1  matrix element valid
m_axis_tlast  out  1  last element of a row
m_axis_tready  in  1  engine ready
res_tdata  in  RW  row result from engine
res_tvalid  in  1  result valid
res_tlast  in  1  engine last-row flag
res_tready  out  1  sequencer accepts result
res_wr_en  out  1  result write strobe
res_wr_idx  out  $clog2(N)  result row index
res_wr_data  out  RW  result value
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion
err_tlast  out  1  sticky: res_tlast disagreed with row count; cleared on next cmd accept

Behaviour:
- Reset values: all outputs 0. Internal state returns to IDLE and the buffer and counters are cleared. cmd_ready goes to 1 on the first clock after areset deasserts.
- Reset mid-job aborts the job immediately. No done pulse is issued, and the partial result is discarded by the bench.
- FSM states: IDLE, VLOAD, STREAM, DRAIN.
- IDLE:
  - cmd_ready=1 and busy=0.
  - On cmd_valid&cmd_ready, latch both bases, clear err_tlast and all counters, and go to VLOAD.
- VLOAD:
  - Issue N consecutive reads, vec_base+0..N-1, one per cycle.
  - Capture each element into vreg[k] one cycle after its read.
  - Go to STREAM in the cycle after the last capture (N+1 cycles total).
  - No engine-side activity occurs in this state.
- STREAM:
  - Issues N*N matrix reads in row-major order through a 2-entry prefetch FIFO.
  - A read is issued only when FIFO occupancy plus reads in flight is less than 2 and reads remain.
  - m_axis_tvalid = FIFO non-empty, and m_axis_tdata = FIFO head.
  - An output column counter c and row counter r advance on each m_axis handshake. m_axis_tlast = (c==N-1).
  - During row 0 only: vec_valid=m_axis_tvalid and vec_data=vreg[c]. A beat pops only when m_axis_tready is 1, and vec_rdy is expected equal to m_axis_tready in that phase.
  - For r>0: vec_valid=0.
  - After the beat with r=N-1 and c=N-1, go to DRAIN.
  - With tready held high, streaming runs at full throughput, one beat per cycle.
- Results (STREAM and DRAIN):
  - res_tready=1 in both states.
  - Each res handshake gives res_wr_en=1 (same cycle, combinational), res_wr_idx = result counter, res_wr_data = res_tdata. The result counter then increments.
  - If res_tlast != (counter==N-1), set err_tlast.
- DRAIN: on acceptance of the Nth result, pulse done for one cycle and go to IDLE. The pulse is registered and appears the cycle after the handshake.
- busy=1 in every state except IDLE.
- cmd_valid outside IDLE is ignored, since cmd_ready=0.
- Address arithmetic wraps modulo 2^AW.
- m_axis_tvalid is never deasserted without a handshake, and tdata/tlast hold stable while tvalid=1 and tready=0.

Test Plan:
- Basic job: N=2, DW=8; mat [[1,2],[3,4]] at 0x10, vec [5,6] at 0x20. Required:
  - Reads at 0x20, 0x21, then 0x10..0x13.
  - Beats 1, 2(tlast), 3, 4(tlast), with vec 5/6 coincident with beats 1/2.
  - Engine results 17 and 39 written at idx 0 and 1, then done pulse and busy=0.
- Backpressure: same job with m_axis_tready low for 3 cycles after beat 1. Required:
  - Beat 2 held stable with no loss or duplication.
  - mem_rd_en stalls once 2 entries are buffered or in flight.
- Address wrap: AW=8, mat_base=0xFE. Required: matrix reads at 0xFE, 0xFF, 0x00, 0x01.
- Command while busy: cmd_valid pulsed during STREAM. Required: cmd_ready=0, the command is ignored, the current job completes, and a second command is accepted afterwards.
- Bad tlast: res_tlast=1 on the first result. Required:
  - err_tlast=1 and held.
  - done still pulses after 2 results.
  - err_tlast cleared on the next cmd accept.
- Reset mid-STREAM: assert areset after beat 2. Required: all outputs are 0 immediately, and a subsequent job produces correct results 17 and 39.

Source files
------------

// File: rtl/mvm_job_sequencer.sv
// Sequences one matrix-vector job: loads the vector, streams the matrix rows to the engine, collects N results.
// Latency: N+1 cycles of vector load, then matrix beats at up to one per cycle; done is registered one cycle after the last result.
// Backpressure: m_axis_tready stalls the 2-entry prefetch and RAM reads; results are always accepted in STREAM/DRAIN.
module mvm_job_sequencer #(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int RW = 2*DW + $clog2(N)
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AW-1:0]        cmd_mat_base,
  input  logic [AW-1:0]        cmd_vec_base,
  output logic                 mem_rd_en,
  output logic [AW-1:0]        mem_rd_addr,
  input  logic [DW-1:0]        mem_rd_data,
  output logic [DW-1:0]        vec_data,
  output logic                 vec_valid,
  input  logic                 vec_rdy,
  output logic [DW-1:0]        m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  input  logic [RW-1:0]        res_tdata,
  input  logic                 res_tvalid,
  input  logic                 res_tlast,
  output logic                 res_tready,
  output logic                 res_wr_en,
  output logic [$clog2(N)-1:0] res_wr_idx,
  output logic [RW-1:0]        res_wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err_tlast
);

  localparam int CW = $clog2(N);
  localparam int MW = $clog2(N*N + 1);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  typedef enum logic [1:0] {S_IDLE, S_VLOAD, S_STREAM, S_DRAIN} state_t;

  state_t          r_state, w_next;
  logic            r_live;
  logic [AW-1:0]   r_mat_base, r_vec_base;
  logic [MW-1:0]   r_rd_cnt;
  logic            r_rd_pend;
  logic [CW-1:0]   r_vcap;
  logic [DW-1:0]   r_vreg [N];
  logic [DW-1:0]   r_fifo [2];
  logic            r_wp, r_rp;
  logic [1:0]      r_cnt;
  logic [CW-1:0]   r_col, r_row, r_res_cnt;
  logic            r_err, r_done;

  // vec_rdy mirrors m_axis_tready during row 0, so the beat handshake keys off tready alone
  logic w_unused_vec_rdy;
  assign w_unused_vec_rdy = vec_rdy;

  logic       w_accept, w_fifo_vld, w_beat, w_last_beat, w_res_rdy, w_res_hs, w_res_last;
  logic       w_vload_rd, w_stream_rd, w_push;
  logic [2:0] w_occ;

  assign w_accept    = cmd_valid & r_live & (r_state == S_IDLE);
  assign w_fifo_vld  = (r_cnt != 2'd0);
  assign w_beat      = w_fifo_vld & m_axis_tready;
  assign w_last_beat = w_beat & (r_row == LAST) & (r_col == LAST);
  assign w_res_rdy   = (r_state == S_STREAM) | (r_state == S_DRAIN);
  assign w_res_hs    = res_tvalid & w_res_rdy;
  assign w_res_last  = (r_res_cnt == LAST);
  assign w_push      = (r_state == S_STREAM) & r_rd_pend;
  // Occupancy seen by the next cycle: current entries minus this cycle's pop plus the read landing now.
  // Counting the pop keeps one beat per cycle with tready high while never exceeding two entries.
  assign w_occ       = 3'(r_cnt) + 3'(r_rd_pend) - 3'(w_beat);
  assign w_vload_rd  = (r_rd_cnt < MW'(N));
  assign w_stream_rd = (r_rd_cnt < MW'(N*N)) & (w_occ < 3'd2);

  assign m_axis_tvalid = w_fifo_vld;
  assign m_axis_tdata  = w_fifo_vld ? r_fifo[r_rp] : '0;
  assign m_axis_tlast  = w_fifo_vld & (r_col == LAST);
  assign vec_data      = vec_valid ? r_vreg[r_col] : '0;
  assign res_wr_en     = w_res_hs;
  assign res_wr_idx    = w_res_hs ? r_res_cnt : '0;
  assign res_wr_data   = w_res_hs ? res_tdata : '0;
  assign done          = r_done;
  assign err_tlast     = r_err;

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_VLOAD;
      S_VLOAD:  if (r_rd_pend && (r_vcap == LAST)) w_next = S_STREAM;
      S_STREAM: if (w_last_beat) w_next = S_DRAIN;
      S_DRAIN:  if (w_res_hs && w_res_last) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; address is held at zero when no read is issued
  always_comb begin
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    res_tready  = w_res_rdy;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    vec_valid   = 1'b0;
    case (r_state)
      S_IDLE:  cmd_ready = r_live;
      S_VLOAD: begin
        busy      = 1'b1;
        mem_rd_en = w_vload_rd;
        if (w_vload_rd) mem_rd_addr = r_vec_base + AW'(r_rd_cnt);
      end
      S_STREAM: begin
        busy      = 1'b1;
        mem_rd_en = w_stream_rd;
        if (w_stream_rd) mem_rd_addr = r_mat_base + AW'(r_rd_cnt);
        vec_valid = w_fifo_vld & (r_row == '0);
      end
      S_DRAIN: busy = 1'b1;
      default: ;
    endcase
  end

  // Job setup, read counter and one-cycle read-in-flight tracking
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_live     <= 1'b0;
      r_mat_base <= '0;
      r_vec_base <= '0;
      r_rd_cnt   <= '0;
      r_rd_pend  <= 1'b0;
    end else begin
      r_live    <= 1'b1;
      r_rd_pend <= mem_rd_en;
      if (w_accept) begin
        r_mat_base <= cmd_mat_base;
        r_vec_base <= cmd_vec_base;
        r_rd_cnt   <= '0;
      end else if ((r_state == S_VLOAD) && (w_next == S_STREAM)) begin
        r_rd_cnt <= '0;
      end else if (mem_rd_en) begin
        r_rd_cnt <= r_rd_cnt + MW'(1);
      end
    end
  end

  // Vector capture during VLOAD
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_vcap <= '0;
      for (int i = 0; i < N; i++) r_vreg[i] <= '0;
    end else if (w_accept) begin
      r_vcap <= '0;
    end else if ((r_state == S_VLOAD) && r_rd_pend) begin
      r_vreg[r_vcap] <= mem_rd_data;
      r_vcap         <= r_vcap + CW'(1);
    end
  end

  // Two-entry matrix prefetch FIFO
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_cnt     <= 2'd0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
    end else if (w_accept) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= mem_rd_data;
        r_wp         <= ~r_wp;
      end
      if (w_beat) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_beat);
    end
  end

  // Output beat position and result collection, tlast checking, done pulse
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_col     <= '0;
      r_row     <= '0;
      r_res_cnt <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == S_DRAIN) & w_res_hs & w_res_last;
      if (w_accept) begin
        r_col     <= '0;
        r_row     <= '0;
        r_res_cnt <= '0;
        r_err     <= 1'b0;
      end else begin
        if (w_beat) begin
          if (r_col == LAST) begin
            r_col <= '0;
            r_row <= r_row + CW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        if (w_res_hs) begin
          r_res_cnt <= r_res_cnt + CW'(1);
          if (res_tlast != w_res_last) r_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mvm_job_sequencer.sv
module tb_mvm_job_sequencer;
  localparam int N  = 2;
  localparam int RW = 17;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [7:0]  cmd_mat_base = 8'h10, cmd_vec_base = 8'h20;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr, mem_rd_data = 8'h00;
  logic [7:0]  vec_data, m_axis_tdata;
  logic        vec_valid, vec_rdy = 1'b1;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b1;
  logic [RW-1:0] res_tdata = '0, res_wr_data;
  logic        res_tvalid = 1'b0, res_tlast = 1'b0, res_tready;
  logic        res_wr_en, busy, done, err_tlast;
  logic [0:0]  res_wr_idx;

  mvm_job_sequencer #(.N(2), .DW(8), .AW(8)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mat_base(cmd_mat_base), .cmd_vec_base(cmd_vec_base),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .vec_data(vec_data), .vec_valid(vec_valid), .vec_rdy(vec_rdy),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .res_tdata(res_tdata), .res_tvalid(res_tvalid), .res_tlast(res_tlast),
    .res_tready(res_tready), .res_wr_en(res_wr_en), .res_wr_idx(res_wr_idx),
    .res_wr_data(res_wr_data), .busy(busy), .done(done), .err_tlast(err_tlast)
  );

  always #5 aclk = ~aclk;

  // Single-port synchronous operand RAM, one cycle read latency
  logic [7:0] ram [256];
  always @(posedge aclk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  typedef struct packed {
    logic crdy; logic busy; logic rden; logic [7:0] addr;
    logic tv; logic [7:0] td; logic tl; logic vv; logic [7:0] vd;
    logic wen; logic widx; logic [16:0] wd; logic dn; logic er;
  } obs_t;

  obs_t obs;
  assign obs = {cmd_ready, busy, mem_rd_en, mem_rd_addr, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                vec_valid, vec_data, res_wr_en, res_wr_idx, res_wr_data, done, err_tlast};

  typedef struct { logic cv; logic tr; logic rv; logic [16:0] rd; logic rl; obs_t ex; } vec_t;
  vec_t tbl[$];

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]  q_addr[$];
  logic [16:0] q_wd[$];
  logic        q_wi[$];
  bit          seen_done;

  function automatic obs_t E(input logic crdy, bsy, rden, input logic [7:0] addr, input logic tv,
                             input logic [7:0] td, input logic tl, vv, input logic [7:0] vd,
                             input logic wen, widx, input logic [16:0] wd, input logic dn, er);
    E = {crdy, bsy, rden, addr, tv, td, tl, vv, vd, wen, widx, wd, dn, er};
  endfunction

  task automatic add(input logic cv, tr, rv, input logic [16:0] rd, input logic rl, input obs_t e);
    vec_t v;
    v.cv = cv; v.tr = tr; v.rv = rv; v.rd = rd; v.rl = rl; v.ex = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drives one job with a simple engine model; records reads and result writes
  task automatic run_job(input logic [7:0] mb, input logic [7:0] vb, input bit bad, input bit poke,
                         input int abort_beats);
    int beats = 0;
    int cyc = 0;
    int nres = 0;
    int col;
    bit fin = 0;
    bit p;
    logic [16:0] acc = '0;
    logic [7:0]  vbuf [2];
    logic [16:0] pend[$];
    vbuf[0] = 8'h00; vbuf[1] = 8'h00;
    q_addr.delete(); q_wd.delete(); q_wi.delete(); seen_done = 0;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_mat_base = mb; cmd_vec_base = vb;
    m_axis_tready = 1'b1; vec_rdy = 1'b1; res_tvalid = 1'b0;
    #2 check("cmd_ready_idle", cmd_ready, 1);
    while (!fin && cyc < 60) begin
      @(negedge aclk);
      cyc++;
      p = poke && (beats == 1);
      cmd_valid    = p;
      cmd_mat_base = p ? 8'h40 : mb;
      res_tvalid   = (pend.size() > 0);
      res_tdata    = res_tvalid ? pend[0] : '0;
      res_tlast    = res_tvalid && ((nres == N-1) != (bad && nres == 0));
      #2;
      if (p) check("cmd_ready_busy", cmd_ready, 0);
      if (mem_rd_en) q_addr.push_back(mem_rd_addr);
      if (m_axis_tvalid && m_axis_tready) begin
        col = beats % N;
        if (beats < N) begin
          check("vec_valid_row0", vec_valid, 1);
          vbuf[col] = vec_data;
        end else begin
          check("vec_valid_rowN", vec_valid, 0);
        end
        check("tlast", m_axis_tlast, (col == N-1));
        acc = acc + 17'(m_axis_tdata) * 17'(vbuf[col]);
        if (col == N-1) begin
          pend.push_back(acc);
          acc = '0;
        end
        beats++;
      end
      if (res_tvalid && res_tready) begin
        nres++;
        pend.delete(0);
      end
      if (res_wr_en) begin
        q_wi.push_back(res_wr_idx);
        q_wd.push_back(res_wr_data);
      end
      if (done) begin
        seen_done = 1;
        fin = 1;
      end
      if (abort_beats != 0 && beats >= abort_beats) fin = 1;
    end
    cmd_valid = 1'b0;
    res_tvalid = 1'b0;
    cmd_mat_base = mb;
    if (!fin) check("job_timeout", 0, 1);
  endtask

  task automatic check_addrs(input logic [47:0] exp);
    check("addr_count", q_addr.size(), 6);
    if (q_addr.size() == 6)
      for (int i = 0; i < 6; i++) check($sformatf("addr%0d", i), q_addr[i], exp[47-8*i -: 8]);
  endtask

  task automatic check_results(input logic exp_err);
    check("done_seen", seen_done, 1);
    check("res_count", q_wd.size(), 2);
    if (q_wd.size() == 2) begin
      check("res0_data", q_wd[0], 17);
      check("res1_data", q_wd[1], 39);
      check("res0_idx", q_wi[0], 0);
      check("res1_idx", q_wi[1], 1);
    end
    check("err_tlast", err_tlast, exp_err);
    check("busy_after", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h10] = 8'd1; ram[8'h11] = 8'd2; ram[8'h12] = 8'd3; ram[8'h13] = 8'd4;
    ram[8'h20] = 8'd5; ram[8'h21] = 8'd6;
    ram[8'hFE] = 8'd1; ram[8'hFF] = 8'd2; ram[8'h00] = 8'd3; ram[8'h01] = 8'd4;

    // Basic job: mat [[1,2],[3,4]] @0x10, vec [5,6] @0x20, tready high
    add(1,1,0, 0,0, E(1,0,0,8'h00, 0,0,0, 0,0, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,1,8'h20, 0,0,0, 0,0, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,1,8'h21, 0,0,0, 0,0, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,0,8'h00, 0,0,0, 0,0, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,1,8'h10, 0,0,0, 0,0, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,1,8'h11, 0,0,0, 0,0, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,1,8'h12, 1,1,0, 1,5, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,1,8'h13, 1,2,1, 1,6, 0,0,0,  0,0));
    add(0,1,1,17,0, E(0,1,0,8'h00, 1,3,0, 0,0, 1,0,17, 0,0));
    add(0,1,0, 0,0, E(0,1,0,8'h00, 1,4,1, 0,0, 0,0,0,  0,0));
    add(0,1,1,39,1, E(0,1,0,8'h00, 0,0,0, 0,0, 1,1,39, 0,0));
    add(0,1,0, 0,0, E(1,0,0,8'h00, 0,0,0, 0,0, 0,0,0,  1,0));
    add(0,1,0, 0,0, E(1,0,0,8'h00, 0,0,0, 0,0, 0,0,0,  0,0));
    // Backpressure: tready low for 3 cycles after beat 1
    add(1,1,0, 0,0, E(1,0,0,8'h00, 0,0,0, 0,0, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,1,8'h20, 0,0,0, 0,0, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,1,8'h21, 0,0,0, 0,0, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,0,8'h00, 0,0,0, 0,0, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,1,8'h10, 0,0,0, 0,0, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,1,8'h11, 0,0,0, 0,0, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,1,8'h12, 1,1,0, 1,5, 0,0,0,  0,0));
    add(0,0,0, 0,0, E(0,1,0,8'h00, 1,2,1, 1,6, 0,0,0,  0,0));
    add(0,0,0, 0,0, E(0,1,0,8'h00, 1,2,1, 1,6, 0,0,0,  0,0));
    add(0,0,0, 0,0, E(0,1,0,8'h00, 1,2,1, 1,6, 0,0,0,  0,0));
    add(0,1,0, 0,0, E(0,1,1,8'h13, 1,2,1, 1,6, 0,0,0,  0,0));
    add(0,1,1,17,0, E(0,1,0,8'h00, 1,3,0, 0,0, 1,0,17, 0,0));
    add(0,1,0, 0,0, E(0,1,0,8'h00, 1,4,1, 0,0, 0,0,0,  0,0));
    add(0,1,1,39,1, E(0,1,0,8'h00, 0,0,0, 0,0, 1,1,39, 0,0));
    add(0,1,0, 0,0, E(1,0,0,8'h00, 0,0,0, 0,0, 0,0,0,  1,0));

    // Reset state
    #12 check("reset_outputs", obs, 0);
    @(negedge aclk);
    areset = 1'b0;
    #1 check("cmd_ready_pre_clk", cmd_ready, 0);
    @(posedge aclk);
    #1 check("cmd_ready_post_clk", cmd_ready, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge aclk);
      cmd_valid = tbl[i].cv; m_axis_tready = tbl[i].tr; vec_rdy = tbl[i].tr;
      res_tvalid = tbl[i].rv; res_tdata = tbl[i].rd; res_tlast = tbl[i].rl;
      #2 check($sformatf("row%0d", i), obs, tbl[i].ex);
    end
    @(negedge aclk);
    cmd_valid = 1'b0; res_tvalid = 1'b0; m_axis_tready = 1'b1; vec_rdy = 1'b1;

    // Address wrap of the matrix base
    run_job(8'hFE, 8'h20, 0, 0, 0);
    check_addrs(48'h20_21_FE_FF_00_01);
    check_results(0);

    // Command pulsed during STREAM is ignored; the next one is accepted
    run_job(8'h10, 8'h20, 0, 1, 0);
    check_addrs(48'h20_21_10_11_12_13);
    check_results(0);
    run_job(8'h10, 8'h20, 0, 0, 0);
    check_results(0);

    // Bad tlast on the first result: sticky error, done still pulses, cleared on next accept
    run_job(8'h10, 8'h20, 1, 0, 0);
    check_results(1);
    @(negedge aclk); @(negedge aclk);
    #2 check("err_tlast_held", err_tlast, 1);
    run_job(8'h10, 8'h20, 0, 0, 0);
    check_results(0);

    // Reset after beat 2 aborts the job; a fresh job then completes correctly
    run_job(8'h10, 8'h20, 0, 0, 2);
    check("abort_no_done", seen_done, 0);
    @(negedge aclk);
    areset = 1'b1;
    #1 check("reset_mid_job", obs, 0);
    @(negedge aclk);
    areset = 1'b0;
    #1 check("cmd_ready_after_abort", cmd_ready, 0);
    run_job(8'h10, 8'h20, 0, 0, 0);
    check_addrs(48'h20_21_10_11_12_13);
    check_results(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
